// File: rtl/fmps_packet_tx.sv
// FMPS fast-link transmitter: builds header+data packets on AXI4-Stream.
// Paced by FA strobes, gated by Aurora channel-up, in the user-clock domain.
module fmps_packet_tx #(
  parameter int          INDEX_WIDTH  = 5,
  parameter logic [15:0] HEADER_MAGIC = 16'hB6CF
) (
  input  logic                   auClk,
  input  logic                   auReset,
  input  logic                   auChannelUp,
  input  logic                   auFAstrobe,
  input  logic                   pktStrobe,
  input  logic [INDEX_WIDTH-1:0] indexBase,
  input  logic [INDEX_WIDTH:0]   pktsPerCycle,
  input  logic [15:0]            dataPayload,
  output logic [31:0]            TX_tdata,
  output logic                   TX_tvalid,
  output logic                   TX_tlast,
  input  logic                   TX_tready,
  output logic [7:0]             cycleCounter,
  output logic                   overrunStrobe
);

  localparam int CW = INDEX_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DAT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] offset_q, offset_d;
  logic [7:0]    cc_ctr_q, cc_ctr_d;
  logic          ovr_q, ovr_d;

  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]             cc_q, cc_d;
  logic [15:0]            pay_q, pay_d;

  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;

  logic [CW:0]            used;
  logic                   room;
  logic                   req_ok;
  logic                   accept;
  logic                   drop;
  logic                   start;
  logic [INDEX_WIDTH-1:0] idx_new;

  function automatic logic [31:0] hdr_word(
    input logic [INDEX_WIDTH-1:0] idx
  );
    logic [4:0] i5;
    i5 = 5'(idx);
    return {HEADER_MAGIC, 1'b0, i5, 10'd0};
  endfunction

  function automatic logic [31:0] dat_word(
    input logic [INDEX_WIDTH-1:0] idx,
    input logic [15:0]            pay,
    input logic [7:0]             cc
  );
    logic [4:0] i5;
    i5 = 5'(idx);
    return {3'b000, i5, pay, cc};
  endfunction

  // Request bookkeeping: how many packets this FA cycle are used/queued.
  assign used    = {1'b0, offset_q} + {1'b0, pending_q};
  assign room    = used < {1'b0, pktsPerCycle};
  assign req_ok  = pktStrobe && auChannelUp && !auFAstrobe;
  assign accept  = req_ok && room;
  assign drop    = req_ok && !room;
  assign start   = (state_q == IDLE) && (pending_q != '0)
                && auChannelUp && !auFAstrobe;
  assign idx_new = indexBase + offset_q[INDEX_WIDTH-1:0];

  // Pending/offset/cycle-counter next state and overrun detection.
  always_comb begin
    pending_d = pending_q;
    offset_d  = offset_q;
    ovr_d     = 1'b0;
    cc_ctr_d  = cc_ctr_q;
    if (auFAstrobe) begin
      cc_ctr_d = cc_ctr_q + 8'd1;
    end
    if (auFAstrobe) begin
      pending_d = '0;
      offset_d  = '0;
      ovr_d     = (pending_q != '0);
    end else if (!auChannelUp) begin
      pending_d = '0;
    end else begin
      if (accept && !start) begin
        pending_d = pending_q + CW'(1);
      end else if (start && !accept) begin
        pending_d = pending_q - CW'(1);
      end
      if (start) begin
        offset_d = offset_q + CW'(1);
      end
      ovr_d = drop;
    end
  end

  // Packet FSM: latch fields at start, hold each beat until accepted.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cc_d     = cc_q;
    pay_d    = pay_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    unique case (state_q)
      IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (start) begin
          idx_d    = idx_new;
          cc_d     = cc_ctr_q;
          pay_d    = dataPayload;
          tdata_d  = hdr_word(idx_new);
          tvalid_d = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        if (TX_tready) begin
          tdata_d = dat_word(idx_q, pay_q, cc_q);
          tlast_d = 1'b1;
          state_d = DAT;
        end
      end
      DAT: begin
        if (TX_tready) begin
          tdata_d  = '0;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge auClk) begin
    if (auReset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      offset_q  <= '0;
      cc_ctr_q  <= '0;
      ovr_q     <= 1'b0;
      idx_q     <= '0;
      cc_q      <= '0;
      pay_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      offset_q  <= offset_d;
      cc_ctr_q  <= cc_ctr_d;
      ovr_q     <= ovr_d;
      idx_q     <= idx_d;
      cc_q      <= cc_d;
      pay_q     <= pay_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
    end
  end

  assign TX_tdata      = tdata_q;
  assign TX_tvalid     = tvalid_q;
  assign TX_tlast      = tlast_q;
  assign cycleCounter  = cc_ctr_q;
  assign overrunStrobe = ovr_q;

endmodule

// File: tb/tb_fmps_packet_tx.sv
// Directed bench for fmps_packet_tx with an expected-word scoreboard.
// Beats are compared on handshake; stalled outputs are checked for stability.
module tb_fmps_packet_tx;

  logic        clk = 1'b0;
  logic        auReset;
  logic        auChannelUp;
  logic        auFAstrobe;
  logic        pktStrobe;
  logic [4:0]  indexBase;
  logic [5:0]  pktsPerCycle;
  logic [15:0] dataPayload;
  logic [31:0] TX_tdata;
  logic        TX_tvalid;
  logic        TX_tlast;
  logic        TX_tready;
  logic [7:0]  cycleCounter;
  logic        overrunStrobe;

  logic rdy_fixed;
  logic rnd_mode;
  logic rnd_bit = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt = 0;

  logic [32:0] expq[$];

  logic [7:0]  m_cc;
  int          m_acc;
  int          m_base;
  logic [15:0] m_pay;

  logic        stall_q = 1'b0;
  logic [33:0] prev_out;

  fmps_packet_tx dut (
    .auClk         (clk),
    .auReset       (auReset),
    .auChannelUp   (auChannelUp),
    .auFAstrobe    (auFAstrobe),
    .pktStrobe     (pktStrobe),
    .indexBase     (indexBase),
    .pktsPerCycle  (pktsPerCycle),
    .dataPayload   (dataPayload),
    .TX_tdata      (TX_tdata),
    .TX_tvalid     (TX_tvalid),
    .TX_tlast      (TX_tlast),
    .TX_tready     (TX_tready),
    .cycleCounter  (cycleCounter),
    .overrunStrobe (overrunStrobe)
  );

  always #5 clk = ~clk;

  assign TX_tready = rnd_mode ? rnd_bit : rdy_fixed;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: overrun pulses, handshake scoreboard, stall stability.
  always @(negedge clk) begin
    logic [32:0] e;
    if (overrunStrobe) ovr_cnt++;
    if (stall_q)
      chk("stall_hold", {30'd0, TX_tvalid, TX_tlast, TX_tdata},
          {30'd0, prev_out});
    if (TX_tvalid && TX_tready && !auReset) begin
      chk("unexpected_beat", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("beat", {31'd0, TX_tlast, TX_tdata}, {31'd0, e});
      end
    end
    stall_q  = TX_tvalid && !TX_tready && !auReset;
    prev_out = {TX_tvalid, TX_tlast, TX_tdata};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fa();
    auFAstrobe = 1'b1;
    tick(1);
    auFAstrobe = 1'b0;
    m_cc  = m_cc + 8'd1;
    m_acc = 0;
  endtask

  task automatic push_pkt(input int acc);
    logic [4:0] ix;
    ix = 5'(m_base + acc);
    expq.push_back({1'b0, 16'hB6CF, 1'b0, ix, 10'd0});
    expq.push_back({1'b1, 3'b000, ix, m_pay, m_cc});
  endtask

  task automatic strobe(input bit expect_pkt);
    if (auChannelUp && (m_acc < int'(pktsPerCycle))) begin
      if (expect_pkt) push_pkt(m_acc);
      m_acc++;
    end
    pktStrobe = 1'b1;
    tick(1);
    pktStrobe = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(expq.size()), 64'd0);
    tick(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int o0;
    int n;
    auReset      = 1'b1;
    auChannelUp  = 1'b0;
    auFAstrobe   = 1'b0;
    pktStrobe    = 1'b0;
    indexBase    = 5'd0;
    pktsPerCycle = 6'd8;
    dataPayload  = 16'hCACA;
    rdy_fixed    = 1'b1;
    rnd_mode     = 1'b0;
    m_cc = 8'd0; m_acc = 0; m_base = 0; m_pay = 16'hCACA;
    tick(3);
    chk("rst_tdata", 64'(TX_tdata), 64'd0);
    chk("rst_tvalid", 64'(TX_tvalid), 64'd0);
    chk("rst_tlast", 64'(TX_tlast), 64'd0);
    chk("rst_cc", 64'(cycleCounter), 64'd0);
    chk("rst_ovr", 64'(overrunStrobe), 64'd0);
    auReset = 1'b0;
    auChannelUp = 1'b1;
    tick(2);

    // 1: eight spaced packets, ready always high
    o0 = ovr_cnt;
    fa();
    chk("cc_after_fa", 64'(cycleCounter), 64'd1);
    for (int i = 0; i < 8; i++) begin
      strobe(1);
      tick(15);
    end
    drain("t1_drain");
    chk("t1_ovr", 64'(ovr_cnt - o0), 64'd0);

    // 2: same with random backpressure
    rnd_mode = 1'b1;
    o0 = ovr_cnt;
    fa();
    for (int i = 0; i < 8; i++) begin
      strobe(1);
      tick(15);
    end
    drain("t2_drain");
    chk("t2_ovr", 64'(ovr_cnt - o0), 64'd0);
    rnd_mode = 1'b0;

    // 3: limit of two per cycle, third dropped
    pktsPerCycle = 6'd2;
    o0 = ovr_cnt;
    fa();
    for (int i = 0; i < 3; i++) begin
      strobe(1);
      tick(15);
    end
    drain("t3_drain");
    chk("t3_ovr", 64'(ovr_cnt - o0), 64'd1);
    fa();
    strobe(1);
    tick(10);
    drain("t3_restart");

    // 4: FA clears queued requests while a packet stalls
    pktsPerCycle = 6'd8;
    rdy_fixed = 1'b0;
    fa();
    o0 = ovr_cnt;
    strobe(1);
    strobe(0);
    strobe(0);
    strobe(0);
    tick(3);
    fa();
    tick(3);
    rdy_fixed = 1'b1;
    drain("t4_drain");
    tick(20);
    chk("t4_ovr", 64'(ovr_cnt - o0), 64'd1);
    chk("t4_idle", 64'(TX_tvalid), 64'd0);

    // 5: channel down ignores strobes; in-flight packet completes
    auChannelUp = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i < 3; i++) begin
      strobe(1);
      tick(3);
    end
    tick(5);
    chk("t5_novalid", 64'(TX_tvalid), 64'd0);
    chk("t5_noovr", 64'(ovr_cnt - o0), 64'd0);
    auChannelUp = 1'b1;
    rdy_fixed = 1'b0;
    fa();
    strobe(1);
    n = 0;
    while (!TX_tvalid && n < 50) begin
      tick(1);
      n++;
    end
    chk("t5_hdr_up", 64'(TX_tvalid), 64'd1);
    auChannelUp = 1'b0;
    tick(5);
    chk("t5_hdr_hold", 64'(TX_tvalid), 64'd1);
    rdy_fixed = 1'b1;
    drain("t5_drain");
    auChannelUp = 1'b1;

    // 6: cycle counter wrap, then index wrap from base 30
    for (int i = 0; i < 256; i++) begin
      fa();
      if (m_cc == 8'd255 || m_cc == 8'd0)
        chk("cc_wrap", 64'(cycleCounter), 64'(m_cc));
    end
    chk("cc_after_256", 64'(cycleCounter), 64'(m_cc));
    indexBase   = 5'd30;
    m_base      = 30;
    dataPayload = 16'h1234;
    m_pay       = 16'h1234;
    o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      strobe(1);
      tick(8);
    end
    drain("t6_drain");
    chk("t6_ovr", 64'(ovr_cnt - o0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fmps_packet_tx.md
Name: fmps_packet_tx

Overview:
- Transmit side of the FMPS fast-link protocol.
- Builds two-word FMPS packets (header + data) and drives them onto an AXI4-Stream toward the Aurora TX core.
- Gated by Aurora channel-up and paced by the FA strobe: one packet per request strobe, with consecutive FMPS indices per FA cycle.
- Sits in the Aurora user-clock domain. Its output is what the FMPS read-link receivers tap and store.

Parameters:
- INDEX_WIDTH, 5, FMPS index width; legal range 1..5 (header/data index fields are 5 bits, zero-extended).
- HEADER_MAGIC, 16'hB6CF, value placed in header word bits [31:16].

Ports:
- auClk  input  1  Aurora user clock; all logic on rising edge.
- auReset  input  1  synchronous, active-high reset.
- auChannelUp  input  1  Aurora channel up.
- auFAstrobe  input  1  single-cycle FA cycle marker.
- pktStrobe  input  1  single-cycle request to send one packet.
- indexBase  input  INDEX_WIDTH  index of first packet in each FA cycle (quasi-static).
- pktsPerCycle  input  INDEX_WIDTH+1  maximum packets per FA cycle (quasi-static); 0 = none.
- dataPayload  input  16  value placed in data word [23:8], sampled at packet start.
- TX_tdata  output  32  AXI stream data.
- TX_tvalid  output  1  AXI stream valid.
- TX_tlast  output  1  high on the data (second) word.
- TX_tready  input  1  AXI stream ready.
- cycleCounter  output  8  current FA cycle counter.
- overrunStrobe  output  1  single-cycle pulse when a request is dropped.

Behaviour:
- Reset: all outputs 0 (tdata, tvalid, tlast, cycleCounter, overrunStrobe). pending=0, offset=0, FSM=IDLE. Reset mid-packet abandons the packet immediately.
- cycleCounter: 8-bit, increments on auFAstrobe, wraps 255->0.
- pending counter: INDEX_WIDTH+1 bits.
  - pktStrobe increments pending if offset+pending < pktsPerCycle; otherwise the request is dropped and overrunStrobe pulses next cycle.
  - Start of a packet decrements pending and increments offset.
  - Simultaneous accepted strobe and packet start leave pending unchanged.
- auFAstrobe:
  - Clears pending and offset in the same cycle.
  - If pending != 0 at that moment, overrunStrobe pulses.
  - auFAstrobe has priority over a coincident pktStrobe: that request is dropped without an overrun pulse.
  - An in-flight packet is unaffected and keeps its latched fields.
- auChannelUp low: pending held at 0 and strobes ignored (no overrun pulse). A packet already in flight completes per AXI rules.
- FSM states:
  - IDLE: tvalid=0. If pending!=0 and auChannelUp and not auFAstrobe, latch:
    - idx = indexBase+offset (mod 2^INDEX_WIDTH)
    - cc = cycleCounter
    - payload = dataPayload
    Then go to HDR with tvalid=1, tlast=0, tdata=header.
  - HDR: hold tdata/tvalid stable until TX_tready. On handshake go to DAT with tdata=data word, tlast=1.
  - DAT: hold until TX_tready. On handshake: tvalid=0, tlast=0, go to IDLE.
- Word formats:
  - Header word: [31:16]=HEADER_MAGIC, [15]=0, [14:10]=idx, [9:0]=0.
  - Data word: [31]=0 (invalidFMPS2CC), [30]=0 (invalidCC2CC), [29]=0 (reserved), [28:24]=idx, [23:8]=payload, [7:0]=cc.
- Latency: from idle with channel up, pktStrobe at cycle N gives pending=1 at N+1 and tvalid high at N+2. With tready held high, a packet occupies 2 beats plus 1 IDLE cycle, so back-to-back packets take 3 cycles each.
- AXI rule: once tvalid is asserted, tvalid, tdata and tlast do not change until the handshake, regardless of auChannelUp or auFAstrobe.
- Index wrap: indexBase=30, offset 3 gives idx=1 (for INDEX_WIDTH=5).

Test Plan:
1. Reset, channel up, indexBase=0, pktsPerCycle=8, dataPayload=16'hCACA, tready=1; FA strobe, then 8 strobes spaced 16 cycles -> 8 packets, idx 0..7.
   - Headers 0xB6CF0000 + (idx<<10).
   - Data 0x00CACA01 | (idx<<24) with cc=1.
   - tlast only on data words; no overrun.
2. Same, but random tready at 50% -> identical word sequence; tdata/tvalid/tlast never change while tvalid=1 and tready=0.
3. pktsPerCycle=2, 3 strobes in one FA cycle -> 2 packets (idx 0,1), one overrunStrobe pulse. Next FA strobe -> offset restarts at idx 0.
4. 4 strobes back-to-back with tready=0, then FA strobe before release -> in-flight packet completes with the old cc. The 3 pending requests are cleared with one overrunStrobe; no further packets are sent.
5. auChannelUp=0 with strobes -> no tvalid, no overrun. Drop channel mid-header with tready=0 -> header and data still complete once tready rises.
6. Run 256 FA strobes -> cycleCounter wraps 255->0; packet cc field matches. indexBase=30 with 4 packets -> idx 30,31,0,1.
